reaction_round_ctrl: RTL and testbench

- Sequential round controller for the reaction-time game.
- Owns the game state register, the random pre-go delay, the millisecond reaction counter and the best-score register.
- Drives the 3-bit state code into the downstream state decoder, which generates the LED, load and clear strobes.
- Supplies the 13-bit reaction and best times for the score display path.

---
 rtl/reaction_round_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_reaction_round_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_round_ctrl.sv
// ---------------------------------------------------------------------------
// reaction_round_ctrl
//
// Sequential round controller for the reaction-time game. Owns the game
// state register, the random pre-go delay, the millisecond reaction counter
// and the best-score register. The 3-bit state code feeds the downstream
// state decoder, which generates the LED, load and clear strobes.
//
// Parameters
//   TICK_DIV     : clock cycles per 1 ms tick
//   MIN_DELAY_MS : fixed part of the pre-go delay (ms)
//   DELAY_BITS   : LFSR bits added to the delay (random part 0..2^DELAY_BITS-1)
//
// Ports
//   clk          : system clock, rising edge
//   reset        : synchronous active-high full reset (clears bestTime too)
//   buttonStart  : debounced level, starts a round (rising edge)
//   buttonHit    : debounced level, player response (rising edge)
//   buttonReset  : debounced level, aborts to IDLE, keeps bestTime
//   state        : state code {s2,s1,s0} for the downstream decoder
//   ledRed       : high in WAIT
//   ledGreen     : high in GO
//   reactionTime : ms of the current or last round (saturates at 8191)
//   bestTime     : lowest valid reactionTime since reset
//   newBest      : one-cycle pulse in the cycle bestTime shows a new value
//   timeout      : high in RESULT when the round saturated
//   foul         : high in FOUL
// ---------------------------------------------------------------------------
module reaction_round_ctrl #(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned DELAY_BITS   = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        buttonStart,
    input  logic        buttonHit,
    input  logic        buttonReset,
    output logic [2:0]  state,
    output logic        ledRed,
    output logic        ledGreen,
    output logic [12:0] reactionTime,
    output logic [12:0] bestTime,
    output logic        newBest,
    output logic        timeout,
    output logic        foul
);

    // Widths derived from the parameters.
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DLY_W = $clog2(MIN_DELAY_MS + (2 ** DELAY_BITS));

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [DLY_W-1:0] MIN_DLY  = DLY_W'(MIN_DELAY_MS);
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;
    localparam logic [12:0]      TIME_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        WAIT   = 3'b001,
        GO     = 3'b010,
        RESULT = 3'b011,
        FOUL   = 3'b100,
        RECORD = 3'b101
    } stateT;

    stateT            stateReg;
    logic [PRE_W-1:0] prescaler;
    logic [DLY_W-1:0] delay;
    logic [DLY_W-1:0] delayLoad;
    logic [15:0]      lfsr;
    logic             lfsrFb;
    logic             startQ;
    logic             hitQ;
    logic             startP;
    logic             hitP;
    logic             timedState;
    logic             tick;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    assign state    = stateReg;
    assign ledRed   = (stateReg == WAIT);
    assign ledGreen = (stateReg == GO);

    assign startP = buttonStart & ~startQ;
    assign hitP   = buttonHit & ~hitQ;

    // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1 (maximal
    // length), shifting left. A non-zero seed never reaches all-zero.
    assign lfsrFb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    assign delayLoad = MIN_DLY + DLY_W'(lfsr[DELAY_BITS-1:0]);

    // The prescaler only runs in WAIT and GO; gating with the state keeps a
    // degenerate TICK_DIV of 1 from ticking in the other states.
    assign timedState = (stateReg == WAIT) || (stateReg == GO);
    assign tick       = timedState && (prescaler == PRE_LAST);

    // ------------------------------------------------------------------
    // State machine and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg     <= IDLE;
            prescaler    <= '0;
            delay        <= '0;
            lfsr         <= LFSR_SEED;
            startQ       <= 1'b1;
            hitQ         <= 1'b1;
            reactionTime <= '0;
            bestTime     <= '1;
            newBest      <= 1'b0;
            timeout      <= 1'b0;
            foul         <= 1'b0;
        end else begin
            // Free-running parts: edge history and LFSR advance every cycle.
            startQ  <= buttonStart;
            hitQ    <= buttonHit;
            lfsr    <= {lfsr[14:0], lfsrFb};
            newBest <= 1'b0;

            // Prescaler defaults to 0; it only counts while staying in WAIT
            // or GO, so every entry into either state starts from 0.
            prescaler <= '0;

            if (buttonReset) begin
                stateReg     <= IDLE;
                reactionTime <= '0;
                timeout      <= 1'b0;
                foul         <= 1'b0;
            end else begin
                case (stateReg)
                    IDLE, RESULT, FOUL: begin
                        if (startP) begin
                            stateReg     <= WAIT;
                            delay        <= delayLoad;
                            reactionTime <= '0;
                            timeout      <= 1'b0;
                            foul         <= 1'b0;
                        end
                    end

                    WAIT: begin
                        // An early hit wins even over the expiry tick.
                        if (hitP) begin
                            stateReg     <= FOUL;
                            foul         <= 1'b1;
                            reactionTime <= '0;
                        end else begin
                            prescaler <= tick ? '0 : prescaler + PRE_W'(1);
                            if (tick) begin
                                if (delay == '0) begin
                                    stateReg <= GO;
                                end else begin
                                    delay <= delay - DLY_W'(1);
                                end
                            end
                        end
                    end

                    GO: begin
                        // A hit freezes the count; a coincident tick is lost.
                        if (hitP) begin
                            stateReg <= RECORD;
                        end else begin
                            prescaler <= tick ? '0 : prescaler + PRE_W'(1);
                            if (tick) begin
                                if (reactionTime == TIME_MAX) begin
                                    stateReg <= RESULT;
                                    timeout  <= 1'b1;
                                end else begin
                                    reactionTime <= reactionTime + 13'd1;
                                end
                            end
                        end
                    end

                    RECORD: begin
                        // Strictly lower only; ties keep the older record.
                        if (reactionTime < bestTime) begin
                            bestTime <= reactionTime;
                            newBest  <= 1'b1;
                        end
                        stateReg <= RESULT;
                    end

                    default: begin
                        stateReg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reaction_round_ctrl
//
// Directed bench for reaction_round_ctrl with TICK_DIV=4, MIN_DELAY_MS=2,
// DELAY_BITS=2. A small LFSR model tracks the pre-go delay so WAIT and GO
// timing can be checked cycle-exactly.
// ---------------------------------------------------------------------------
module tb_reaction_round_ctrl;

    localparam int unsigned TD = 4;
    localparam int unsigned MD = 2;
    localparam int unsigned DB = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        buttonStart;
    logic        buttonHit;
    logic        buttonReset;
    logic [2:0]  state;
    logic        ledRed;
    logic        ledGreen;
    logic [12:0] reactionTime;
    logic [12:0] bestTime;
    logic        newBest;
    logic        timeout;
    logic        foul;

    int cmpCount = 0;
    int errCount = 0;
    int curDelay = 0;

    logic [15:0] mLfsr = 16'hACE1;
    logic [15:0] lfsrPrev = 16'hACE1;

    reaction_round_ctrl #(
        .TICK_DIV    (TD),
        .MIN_DELAY_MS(MD),
        .DELAY_BITS  (DB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .buttonStart (buttonStart),
        .buttonHit   (buttonHit),
        .buttonReset (buttonReset),
        .state       (state),
        .ledRed      (ledRed),
        .ledGreen    (ledGreen),
        .reactionTime(reactionTime),
        .bestTime    (bestTime),
        .newBest     (newBest),
        .timeout     (timeout),
        .foul        (foul)
    );

    always #5 clk = ~clk;

    // Reference LFSR (x^16+x^14+x^13+x^11+1, left shift). lfsrPrev holds the
    // value the design saw at the most recent edge.
    always @(posedge clk) begin
        lfsrPrev <= mLfsr;
        if (reset) mLfsr <= 16'hACE1;
        else       mLfsr <= {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Press start for one edge and derive the loaded delay from the model.
    task automatic startRound();
        logic [15:0] v;
        buttonStart = 1'b1;
        step();
        v = lfsrPrev;
        curDelay = int'(MD) + int'(v[1:0]);
        buttonStart = 1'b0;
    endtask

    // WAIT lasts (delay+1) ticks of TD cycles each.
    task automatic runToGo();
        repeat (int'(TD) * (curDelay + 1)) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; buttonStart = 1'b1; buttonHit = 1'b1; buttonReset = 1'b1;
        repeat (3) step();
        cmpCount++;
        if ({state, reactionTime, bestTime, newBest, timeout, foul, ledRed, ledGreen}
            !== {3'b000, 13'd0, 13'h1FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errCount++;
            $display("FAIL reset_values: state=%b rt=%0d best=%0d nb=%b to=%b foul=%b red=%b green=%b expected 000/0/8191/0/0/0/0/0",
                     state, reactionTime, bestTime, newBest, timeout, foul, ledRed, ledGreen);
        end
        reset = 1'b0; buttonReset = 1'b0;
        repeat (4) step();
        cmpCount++;
        if (state !== 3'b000) begin
            errCount++;
            $display("FAIL held_start_no_edge: state=%b expected 000", state);
        end
        buttonStart = 1'b0; buttonHit = 1'b0;
        step();
        cmpCount++;
        if (state !== 3'b000) begin
            errCount++;
            $display("FAIL release_idle: state=%b expected 000", state);
        end
        startRound();
        cmpCount++;
        if ({state, bestTime, reactionTime, ledRed} !== {3'b001, 13'd8191, 13'd0, 1'b1}) begin
            errCount++;
            $display("FAIL repress_start: state=%b best=%0d rt=%0d red=%b expected 001/8191/0/1",
                     state, bestTime, reactionTime, ledRed);
        end
        buttonReset = 1'b1;
        step();
        buttonReset = 1'b0;
        cmpCount++;
        if (state !== 3'b000) begin
            errCount++;
            $display("FAIL abort_to_idle: state=%b expected 000", state);
        end
    endtask

    task automatic test_first_round();
        startRound();
        repeat (int'(TD) * (curDelay + 1) - 1) step();
        cmpCount++;
        if ({state, ledGreen} !== {3'b001, 1'b0}) begin
            errCount++;
            $display("FAIL wait_length: state=%b green=%b expected 001/0 (delay %0d)", state, ledGreen, curDelay);
        end
        step();
        cmpCount++;
        if ({state, ledRed, ledGreen} !== {3'b010, 1'b0, 1'b1}) begin
            errCount++;
            $display("FAIL go_entry: state=%b red=%b green=%b expected 010/0/1", state, ledRed, ledGreen);
        end
        repeat (20) step();
        cmpCount++;
        if ({state, reactionTime} !== {3'b010, 13'd5}) begin
            errCount++;
            $display("FAIL go_count: state=%b rt=%0d expected 010/5", state, reactionTime);
        end
        buttonHit = 1'b1;
        step();
        buttonHit = 1'b0;
        cmpCount++;
        if ({state, newBest, reactionTime} !== {3'b101, 1'b0, 13'd5}) begin
            errCount++;
            $display("FAIL record_state: state=%b nb=%b rt=%0d expected 101/0/5", state, newBest, reactionTime);
        end
        step();
        cmpCount++;
        if ({state, reactionTime, bestTime, newBest} !== {3'b011, 13'd5, 13'd5, 1'b1}) begin
            errCount++;
            $display("FAIL result_best: state=%b rt=%0d best=%0d nb=%b expected 011/5/5/1",
                     state, reactionTime, bestTime, newBest);
        end
        step();
        cmpCount++;
        if ({state, newBest} !== {3'b011, 1'b0}) begin
            errCount++;
            $display("FAIL newbest_pulse: state=%b nb=%b expected 011/0", state, newBest);
        end
    endtask

    task automatic playRound(input int hitTicks);
        startRound();
        runToGo();
        repeat (int'(TD) * hitTicks) step();
        buttonHit = 1'b1;
        step();
        buttonHit = 1'b0;
        step();
    endtask

    task automatic test_no_update();
        playRound(7);
        cmpCount++;
        if ({state, reactionTime, bestTime, newBest} !== {3'b011, 13'd7, 13'd5, 1'b0}) begin
            errCount++;
            $display("FAIL slower_round: state=%b rt=%0d best=%0d nb=%b expected 011/7/5/0",
                     state, reactionTime, bestTime, newBest);
        end
        playRound(5);
        cmpCount++;
        if ({state, reactionTime, bestTime, newBest} !== {3'b011, 13'd5, 13'd5, 1'b0}) begin
            errCount++;
            $display("FAIL equal_round: state=%b rt=%0d best=%0d nb=%b expected 011/5/5/0",
                     state, reactionTime, bestTime, newBest);
        end
    endtask

    task automatic test_foul();
        logic sawGreen;
        startRound();
        repeat (2) step();
        buttonHit = 1'b1;
        step();
        buttonHit = 1'b0;
        cmpCount++;
        if ({state, foul, reactionTime, ledGreen} !== {3'b100, 1'b1, 13'd0, 1'b0}) begin
            errCount++;
            $display("FAIL early_foul: state=%b foul=%b rt=%0d green=%b expected 100/1/0/0",
                     state, foul, reactionTime, ledGreen);
        end
        startRound();
        cmpCount++;
        if ({state, foul} !== {3'b001, 1'b0}) begin
            errCount++;
            $display("FAIL foul_restart: state=%b foul=%b expected 001/0", state, foul);
        end
        // Hit lands on the very edge that carries the expiry tick.
        sawGreen = 1'b0;
        repeat (int'(TD) * (curDelay + 1) - 1) begin
            step();
            sawGreen = sawGreen | ledGreen;
        end
        buttonHit = 1'b1;
        step();
        buttonHit = 1'b0;
        sawGreen = sawGreen | ledGreen;
        cmpCount++;
        if ({state, foul, sawGreen} !== {3'b100, 1'b1, 1'b0}) begin
            errCount++;
            $display("FAIL expiry_foul: state=%b foul=%b sawGreen=%b expected 100/1/0", state, foul, sawGreen);
        end
        startRound();
        cmpCount++;
        if ({state, foul} !== {3'b001, 1'b0}) begin
            errCount++;
            $display("FAIL foul_restart2: state=%b foul=%b expected 001/0", state, foul);
        end
        buttonReset = 1'b1;
        step();
        buttonReset = 1'b0;
    endtask

    task automatic test_saturation();
        startRound();
        runToGo();
        repeat (int'(TD) * 8191 + 3) step();
        cmpCount++;
        if ({state, reactionTime, timeout} !== {3'b010, 13'd8191, 1'b0}) begin
            errCount++;
            $display("FAIL near_saturation: state=%b rt=%0d to=%b expected 010/8191/0", state, reactionTime, timeout);
        end
        step();
        cmpCount++;
        if ({state, reactionTime, timeout, bestTime, newBest} !== {3'b011, 13'd8191, 1'b1, 13'd5, 1'b0}) begin
            errCount++;
            $display("FAIL timeout_result: state=%b rt=%0d to=%b best=%0d nb=%b expected 011/8191/1/5/0",
                     state, reactionTime, timeout, bestTime, newBest);
        end
        repeat (6) step();
        buttonHit = 1'b1;
        step();
        buttonHit = 1'b0;
        step();
        cmpCount++;
        if ({state, reactionTime, timeout, bestTime} !== {3'b011, 13'd8191, 1'b1, 13'd5}) begin
            errCount++;
            $display("FAIL result_hold: state=%b rt=%0d to=%b best=%0d expected 011/8191/1/5",
                     state, reactionTime, timeout, bestTime);
        end
    endtask

    task automatic test_abort_and_reset();
        startRound();
        cmpCount++;
        if ({state, timeout, reactionTime} !== {3'b001, 1'b0, 13'd0}) begin
            errCount++;
            $display("FAIL restart_clears: state=%b to=%b rt=%0d expected 001/0/0", state, timeout, reactionTime);
        end
        runToGo();
        repeat (12) step();
        cmpCount++;
        if ({state, reactionTime} !== {3'b010, 13'd3}) begin
            errCount++;
            $display("FAIL pre_abort: state=%b rt=%0d expected 010/3", state, reactionTime);
        end
        buttonReset = 1'b1;
        step();
        buttonReset = 1'b0;
        cmpCount++;
        if ({state, reactionTime, bestTime, ledGreen} !== {3'b000, 13'd0, 13'd5, 1'b0}) begin
            errCount++;
            $display("FAIL abort_go: state=%b rt=%0d best=%0d green=%b expected 000/0/5/0",
                     state, reactionTime, bestTime, ledGreen);
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cmpCount++;
        if ({state, bestTime} !== {3'b000, 13'd8191}) begin
            errCount++;
            $display("FAIL reset_best: state=%b best=%0d expected 000/8191", state, bestTime);
        end
    endtask

    initial begin
        reset = 1'b1; buttonStart = 1'b0; buttonHit = 1'b0; buttonReset = 1'b0;
        test_reset();
        test_first_round();
        test_no_update();
        test_foul();
        test_saturation();
        test_abort_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
